vic20_loader_ctrl: RTL and testbench
====================================

Name: vic20_loader_ctrl

Overview:
- Sequences all HPS download traffic into the VIC20 configuration write port (conf_ai/conf_di/conf_wr, clk_sys domain).
- Covers four sources:
  - Kernal/BASIC ROM image (index 0).
  - PRG file (index 1).
  - CRT with load-address header (index 2).
  - Raw CT? cart, base address taken from the file extension (index 3).
- After a PRG load it runs a timed patch sequence that writes the BASIC end-of-program pointers.
- Tracks which cartridge 8 KB blocks were populated and holds the core in cart reset during cart loads.

Parameters:
- PRG_LIMIT, 16'hA000: first PRG address that is not written; later bytes are dropped.
- CART_LIMIT, 16'hC000: first cart address that is not written.
- PATCH_GAP, 1: idle cycles inserted between consecutive patch writes (0..15).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download source index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  byte data.
- ioctl_file_ext  in  32  file extension, ASCII; [7:0] is the last character.
- conf_ai  out  16  configuration write address.
- conf_di  out  8  configuration write data.
- conf_wr  out  1  one-cycle write strobe.
- cart_blk  out  5  populated blocks: bit0 $0000, bit1 $2000, bit2 $4000, bit3 $6000, bit4 $A000.
- cart_reset  out  1  hold core in reset during a cart load.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): every output is 0, state IDLE, load address register 0.
- States: IDLE, HDR_LO, HDR_HI, DATA, PATCH, (KEYBUF), ABORT-free.
- At most one conf_wr per cycle.
- Write latency: 1 cycle from ioctl_wr to conf_wr, with conf_ai/conf_di valid in the same cycle as conf_wr.
- Download start is the rising edge of ioctl_download; end is the falling edge.
- Start with index 0 → DATA(ROM).
  - Each byte whose ioctl_addr lies in [$4000,$7FFF] is written to ioctl_addr[15:0]+$8000.
  - Other bytes are ignored.
  - No patch runs afterwards.
- Start with index 1 → HDR_LO. Byte 0 → addr[7:0], byte 1 → addr[15:8], then DATA(PRG).
  - Each byte is written to addr if addr < PRG_LIMIT, then addr increments.
  - Once addr ≥ PRG_LIMIT, bytes are dropped and addr stops incrementing.
- Start with index 2 → HDR_LO/HDR_HI as for PRG, then DATA(CART).
- Start with index 3 → DATA(CART) directly, with addr set from ioctl_file_ext[7:0]:
  - '2'..'9' → {digit,12'h000}.
  - 'A','B' → $A000, $B000.
  - Any other character → $A000.
- DATA(CART):
  - Each byte is written if addr < CART_LIMIT.
  - Sets cart_blk bit for addr[15:13] ∈ {000,001,010,011,101}; addresses in $8000-$9FFF set no bit.
  - Increments addr.
- cart_reset:
  - Set in the start cycle of index 2 or 3.
  - Cleared one cycle after the download ends.
- cart_blk is sticky: it is cleared only by reset, not by new cart loads.
- PRG end with both header bytes received → PATCH.
  - Eight writes: $2D,$2F,$31,$AE ← addr[7:0]; $2E,$30,$32,$AF ← addr[15:8].
  - Written in address order $2D,$2E,$2F,$30,$31,$32,$AE,$AF.
  - Consecutive writes are separated by PATCH_GAP idle cycles.
  - Then IDLE (or KEYBUF when the optional feature is compiled in).
- PRG end with fewer than 2 bytes received → IDLE, no patch.
- Download start while in PATCH/KEYBUF:
  - The remaining sequence is abandoned.
  - The new download is handled from its first byte with no lost writes.
- An unknown index (>3) is ignored: the controller stays IDLE.
- The high bits of ioctl_addr are not checked beyond the rules above.

Optional Feature:
- Macro: LOADER_AUTORUN_EN.
- Defined: after PATCH, state KEYBUF writes:
  - "R","U","N",$0D to $0277..$027A.
  - Then $04 to $00C6 (keyboard buffer count).
  - Same PATCH_GAP spacing, abortable like PATCH.
- Undefined: the KEYBUF state and its logic are absent, and PATCH returns to IDLE.

Decomposition:
- Package vic20_loader_pkg holds:
  - state enum;
  - index constants IDX_ROM=0, IDX_PRG=1, IDX_CRT=2, IDX_CT=3;
  - patch address table (8×16 bit);
  - autorun byte table.
- One sub-module, loader_seq_rom: a small indexed write sequencer (address/data table, gap counter, done, abort).
  - Reused by PATCH and KEYBUF.

Test Plan:
- PRG index 1, bytes 01 10 AA BB CC → writes $1001←AA, $1002←BB, $1003←CC; then $2D←04, $2E←10, … $AF←10 with a 1-cycle gap; busy falls after the last write.
- PRG header 00 9F followed by 0x1100 data bytes → writes stop at $9FFF; patch writes $00/$A0.
- CT? with extension "A0" → first byte at $A000; cart_blk=5'b10000; cart_reset high for the whole load, low 1 cycle after the end.
- ROM index 0, 32 KB → only offsets $4000-$7FFF are written, to $C000-$FFFF; no patch.
- A new PRG download starts during the 3rd patch write → no further patch writes; the new header is captured correctly.
- Reset asserted mid-DATA → all outputs 0 asynchronously; cart_blk cleared; a subsequent load behaves normally.
- With LOADER_AUTORUN_EN defined, after a PRG load → writes $0277..$027A = 52 55 4E 0D, then $C6=04.

Source files
------------

// File: rtl/vic20_loader_pkg.sv
// Shared types and tables for the VIC20 download sequencer.
// LOADER_AUTORUN_EN adds the KEYBUF state (autorun "RUN<CR>" injection).
package vic20_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_PATCH
`ifdef LOADER_AUTORUN_EN
        , ST_KEYBUF
`endif
    } loader_state_t;

    typedef enum logic [1:0] {
        MODE_ROM,
        MODE_PRG,
        MODE_CART
    } load_mode_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_PRG = 8'd1;
    localparam logic [7:0] IDX_CRT = 8'd2;
    localparam logic [7:0] IDX_CT  = 8'd3;

    localparam logic [2:0] PATCH_LAST   = 3'd7;
    localparam logic [2:0] AUTORUN_LAST = 3'd4;

    // Even entries take the pointer low byte, odd entries the high byte.
    localparam logic [15:0] PATCH_ADDR [8] = '{
        16'h002D, 16'h002E, 16'h002F, 16'h0030,
        16'h0031, 16'h0032, 16'h00AE, 16'h00AF
    };

    localparam logic [15:0] AUTORUN_ADDR [5] = '{
        16'h0277, 16'h0278, 16'h0279, 16'h027A, 16'h00C6
    };

    localparam logic [7:0] AUTORUN_DATA [5] = '{
        8'h52, 8'h55, 8'h4E, 8'h0D, 8'h04
    };

    function automatic logic [15:0] ct_base(input logic [7:0] ch);
        logic [15:0] base;
        base = 16'hA000;
        if (ch >= 8'h32 && ch <= 8'h39)
            base = {ch[3:0], 12'h000};
        else if (ch == 8'h42)
            base = 16'hB000;
        return base;
    endfunction

    function automatic logic [4:0] cart_blk_bit(input logic [2:0] region);
        logic [4:0] bits;
        case (region)
            3'd0:    bits = 5'b00001;
            3'd1:    bits = 5'b00010;
            3'd2:    bits = 5'b00100;
            3'd3:    bits = 5'b01000;
            3'd5:    bits = 5'b10000;
            default: bits = 5'b00000;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/vic20_loader_ctrl_seq.sv
// Indexed table write sequencer shared by the BASIC pointer patch and the
// keyboard-buffer autorun; emits one write request per GAP+1 cycles.
module loader_seq_rom
    import vic20_loader_pkg::*;
#(
    parameter int unsigned GAP = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        chain,
    input  logic        abort,
    input  logic [15:0] ptr,
    output logic        req,
    output logic        last,
    output logic [15:0] ai,
    output logic [7:0]  di
);

    localparam logic [3:0] GAP4 = 4'(GAP);

    logic       active;
    logic       sel;
    logic [2:0] idx;
    logic [3:0] gap_cnt;
    logic [2:0] end_idx;

    always_comb begin
        end_idx = sel ? AUTORUN_LAST : PATCH_LAST;
        req     = active && (gap_cnt == '0) && !abort;
        last    = req && (idx == end_idx);
        if (sel) begin
            ai = AUTORUN_ADDR[idx];
            di = AUTORUN_DATA[idx];
        end else begin
            ai = PATCH_ADDR[idx];
            di = idx[0] ? ptr[15:8] : ptr[7:0];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            sel     <= 1'b0;
            idx     <= '0;
            gap_cnt <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            sel     <= 1'b0;
            idx     <= '0;
            gap_cnt <= '0;
        end else if (active) begin
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end else begin
                gap_cnt <= GAP4;
                if (idx == end_idx) begin
                    // Chaining rolls straight into the autorun table, keeping the gap.
                    if (chain && !sel) begin
                        sel <= 1'b1;
                        idx <= '0;
                    end else begin
                        active <= 1'b0;
                    end
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vic20_loader_ctrl.sv
// VIC20 HPS download controller: ROM/PRG/CRT/CT? into the config write port.
// Define LOADER_AUTORUN_EN to append the keyboard-buffer "RUN" injection.
module vic20_loader_ctrl
    import vic20_loader_pkg::*;
#(
    parameter logic [15:0] PRG_LIMIT  = 16'hA000,
    parameter logic [15:0] CART_LIMIT = 16'hC000,
    parameter int unsigned PATCH_GAP  = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [31:0] ioctl_file_ext,
    output logic [15:0] conf_ai,
    output logic [7:0]  conf_di,
    output logic        conf_wr,
    output logic [4:0]  cart_blk,
    output logic        cart_reset,
    output logic        busy
);

    loader_state_t state, eff_state;
    load_mode_t    mode, eff_mode;
    logic [15:0]   load_addr, eff_addr;
    logic          dl_q, dl_rise, dl_fall;
    logic          in_seq, seq_start, seq_abort, seq_chain, seq_req, seq_last;
    logic [15:0]   seq_ai;
    logic [7:0]    seq_di;
    logic          unused_bits;

    assign unused_bits = ^{ioctl_addr[24:16], ioctl_file_ext[31:8]};
    assign busy        = (state != ST_IDLE) || conf_wr;

    // eff_* is the context as it will be after a start edge, so a byte strobe
    // arriving in the very first download cycle is still handled.
    always_comb begin
        dl_rise = ioctl_download && !dl_q;
        dl_fall = !ioctl_download && dl_q;
`ifdef LOADER_AUTORUN_EN
        in_seq    = (state == ST_PATCH) || (state == ST_KEYBUF);
        seq_chain = (state == ST_PATCH);
`else
        in_seq    = (state == ST_PATCH);
        seq_chain = 1'b0;
`endif
        seq_abort = dl_rise && in_seq;
        seq_start = dl_fall && (state == ST_DATA) && (mode == MODE_PRG);
        eff_state = state;
        eff_mode  = mode;
        eff_addr  = load_addr;
        if (dl_rise) begin
            eff_state = ST_IDLE;
            case (ioctl_index)
                IDX_ROM: begin eff_state = ST_DATA;   eff_mode = MODE_ROM;  end
                IDX_PRG: begin eff_state = ST_HDR_LO; eff_mode = MODE_PRG;  end
                IDX_CRT: begin eff_state = ST_HDR_LO; eff_mode = MODE_CART; end
                IDX_CT: begin
                    eff_state = ST_DATA;
                    eff_mode  = MODE_CART;
                    eff_addr  = ct_base(ioctl_file_ext[7:0]);
                end
                default: ;
            endcase
        end
    end

    loader_seq_rom #(.GAP(PATCH_GAP)) u_seq (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (seq_start),
        .chain   (seq_chain),
        .abort   (seq_abort),
        .ptr     (load_addr),
        .req     (seq_req),
        .last    (seq_last),
        .ai      (seq_ai),
        .di      (seq_di)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode       <= MODE_ROM;
            load_addr  <= '0;
            dl_q       <= 1'b0;
            conf_ai    <= '0;
            conf_di    <= '0;
            conf_wr    <= 1'b0;
            cart_blk   <= '0;
            cart_reset <= 1'b0;
        end else begin
            conf_wr <= 1'b0;
            dl_q    <= ioctl_download;

            if (dl_rise) begin
                state      <= eff_state;
                mode       <= eff_mode;
                load_addr  <= eff_addr;
                cart_reset <= (ioctl_index == IDX_CRT) || (ioctl_index == IDX_CT);
            end else if (dl_fall) begin
                cart_reset <= 1'b0;
                if (state == ST_HDR_LO || state == ST_HDR_HI || state == ST_DATA)
                    state <= seq_start ? ST_PATCH : ST_IDLE;
            end else if (seq_req) begin
                conf_wr <= 1'b1;
                conf_ai <= seq_ai;
                conf_di <= seq_di;
                if (seq_last) begin
`ifdef LOADER_AUTORUN_EN
                    state <= seq_chain ? ST_KEYBUF : ST_IDLE;
`else
                    state <= ST_IDLE;
`endif
                end
            end

            if (ioctl_download && ioctl_wr) begin
                case (eff_state)
                    ST_HDR_LO: begin
                        load_addr[7:0] <= ioctl_dout;
                        state          <= ST_HDR_HI;
                    end
                    ST_HDR_HI: begin
                        load_addr[15:8] <= ioctl_dout;
                        state           <= ST_DATA;
                    end
                    ST_DATA: begin
                        case (eff_mode)
                            MODE_ROM: begin
                                if (ioctl_addr[15:14] == 2'b01) begin
                                    conf_wr <= 1'b1;
                                    conf_ai <= {2'b11, ioctl_addr[13:0]};
                                    conf_di <= ioctl_dout;
                                end
                            end
                            MODE_PRG: begin
                                if (eff_addr < PRG_LIMIT) begin
                                    conf_wr   <= 1'b1;
                                    conf_ai   <= eff_addr;
                                    conf_di   <= ioctl_dout;
                                    load_addr <= eff_addr + 16'd1;
                                end
                            end
                            MODE_CART: begin
                                if (eff_addr < CART_LIMIT) begin
                                    conf_wr <= 1'b1;
                                    conf_ai <= eff_addr;
                                    conf_di <= ioctl_dout;
                                end
                                cart_blk  <= cart_blk | cart_blk_bit(eff_addr[15:13]);
                                load_addr <= eff_addr + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vic20_loader_ctrl.sv
// Directed self-checking bench for vic20_loader_ctrl (default and LOADER_AUTORUN_EN builds).
module tb_vic20_loader_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [31:0] ioctl_file_ext = '0;
    logic [15:0] conf_ai;
    logic [7:0]  conf_di;
    logic        conf_wr;
    logic [4:0]  cart_blk;
    logic        cart_reset;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] wq_ai[$];
    logic [7:0]  wq_di[$];
    int          wq_cyc[$];
    logic [15:0] eq_ai[$];
    logic [7:0]  eq_di[$];

    vic20_loader_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_file_ext (ioctl_file_ext),
        .conf_ai        (conf_ai),
        .conf_di        (conf_di),
        .conf_wr        (conf_wr),
        .cart_blk       (cart_blk),
        .cart_reset     (cart_reset),
        .busy           (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (conf_wr === 1'b1) begin
            wq_ai.push_back(conf_ai);
            wq_di.push_back(conf_di);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic exp_push(input logic [15:0] a, input logic [7:0] d);
        eq_ai.push_back(a);
        eq_di.push_back(d);
    endtask

    task automatic exp_patch(input logic [15:0] p);
        exp_push(16'h002D, p[7:0]);
        exp_push(16'h002E, p[15:8]);
        exp_push(16'h002F, p[7:0]);
        exp_push(16'h0030, p[15:8]);
        exp_push(16'h0031, p[7:0]);
        exp_push(16'h0032, p[15:8]);
        exp_push(16'h00AE, p[7:0]);
        exp_push(16'h00AF, p[15:8]);
`ifdef LOADER_AUTORUN_EN
        exp_push(16'h0277, 8'h52);
        exp_push(16'h0278, 8'h55);
        exp_push(16'h0279, 8'h4E);
        exp_push(16'h027A, 8'h0D);
        exp_push(16'h00C6, 8'h04);
`endif
    endtask

    task automatic dl_start(input logic [7:0] idx, input logic [31:0] ext);
        tick;
        ioctl_index    = idx;
        ioctl_file_ext = ext;
        ioctl_download = 1'b1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        tick;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick;
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_end;
        tick;
        ioctl_download = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " count"}, wq_ai.size(), eq_ai.size());
        for (int i = 0; i < eq_ai.size() && i < wq_ai.size(); i++)
            check($sformatf("%s #%0d", tag, i), {8'd0, wq_ai[i], wq_di[i]}, {8'd0, eq_ai[i], eq_di[i]});
        wq_ai.delete();
        wq_di.delete();
        wq_cyc.delete();
        eq_ai.delete();
        eq_di.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset values
        #23;
        check("rst conf", {7'd0, conf_wr, conf_ai, conf_di}, 32'd0);
        check("rst blk", {27'd0, cart_blk}, 32'd0);
        check("rst cart_reset", {31'd0, cart_reset}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        tick;
        reset = 1'b0;
        repeat (2) tick;

        // PRG: header 01 10, data AA BB CC, then pointer patch with $1004
        dl_start(8'd1, 32'd0);
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h10);
        send_byte(25'd2, 8'hAA);
        check("prg latency", {15'd0, conf_wr, conf_ai}, {15'd0, 1'b1, 16'h1001});
        send_byte(25'd3, 8'hBB);
        send_byte(25'd4, 8'hCC);
        dl_end;
        wait_idle("prg idle");
        exp_push(16'h1001, 8'hAA);
        exp_push(16'h1002, 8'hBB);
        exp_push(16'h1003, 8'hCC);
        exp_patch(16'h1004);
        if (wq_cyc.size() >= 11) begin
            check("prg gap a", wq_cyc[4] - wq_cyc[3], 32'd2);
            check("prg gap b", wq_cyc[10] - wq_cyc[9], 32'd2);
        end
        check_writes("prg");

        // PRG at limit: header $9F00, 0x1100 bytes, stops at $9FFF
        dl_start(8'd1, 32'd0);
        send_byte(25'd0, 8'h00);
        send_byte(25'd1, 8'h9F);
        for (int i = 0; i < 32'h1100; i++) begin
            send_byte(25'(i + 2), 8'(i));
            if (i < 256) exp_push(16'h9F00 + 16'(i), 8'(i));
        end
        dl_end;
        wait_idle("lim idle");
        exp_patch(16'hA000);
        check_writes("lim");

        // PRG with a single header byte: no patch
        dl_start(8'd1, 32'd0);
        send_byte(25'd0, 8'h01);
        dl_end;
        wait_idle("short idle");
        check_writes("short");

        // CT? with ext "A0": last char '0' falls back to $A000
        dl_start(8'd3, 32'h0000_4130);
        tick;
        check("ct cart_reset on", {31'd0, cart_reset}, 32'd1);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        send_byte(25'd2, 8'h33);
        check("ct cart_reset mid", {31'd0, cart_reset}, 32'd1);
        dl_end;
        @(negedge clk_sys);
        check("ct cart_reset end", {31'd0, cart_reset}, 32'd1);
        @(negedge clk_sys);
        check("ct cart_reset off", {31'd0, cart_reset}, 32'd0);
        wait_idle("ct idle");
        check("ct blk", {27'd0, cart_blk}, 32'h10);
        exp_push(16'hA000, 8'h11);
        exp_push(16'hA001, 8'h22);
        exp_push(16'hA002, 8'h33);
        check_writes("ct");

        // CT? with ext "CT2": base $2000, cart_blk accumulates
        dl_start(8'd3, 32'h0043_5432);
        send_byte(25'd0, 8'h44);
        dl_end;
        wait_idle("ct2 idle");
        check("ct2 blk", {27'd0, cart_blk}, 32'h12);
        exp_push(16'h2000, 8'h44);
        check_writes("ct2");

        // CRT with header $6000: no patch afterwards
        dl_start(8'd2, 32'd0);
        send_byte(25'd0, 8'h00);
        send_byte(25'd1, 8'h60);
        send_byte(25'd2, 8'h55);
        send_byte(25'd3, 8'h66);
        dl_end;
        wait_idle("crt idle");
        check("crt blk", {27'd0, cart_blk}, 32'h1A);
        exp_push(16'h6000, 8'h55);
        exp_push(16'h6001, 8'h66);
        check_writes("crt");

        // ROM: only offsets $4000-$7FFF land, at +$8000
        dl_start(8'd0, 32'd0);
        send_byte(25'h0000, 8'h01);
        send_byte(25'h3FFF, 8'h02);
        send_byte(25'h4000, 8'h03);
        send_byte(25'h5555, 8'h04);
        send_byte(25'h7FFF, 8'h05);
        send_byte(25'h8000, 8'h06);
        send_byte(25'hC123, 8'h07);
        dl_end;
        wait_idle("rom idle");
        exp_push(16'hC000, 8'h03);
        exp_push(16'hD555, 8'h04);
        exp_push(16'hFFFF, 8'h05);
        check_writes("rom");

        // Unknown index is ignored
        dl_start(8'd5, 32'd0);
        send_byte(25'd0, 8'h12);
        check("unk busy", {31'd0, busy}, 32'd0);
        dl_end;
        wait_idle("unk idle");
        check_writes("unk");

        // New PRG download during the 3rd patch write aborts the patch
        dl_start(8'd1, 32'd0);
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h10);
        send_byte(25'd2, 8'hAA);
        dl_end;
        n = 0;
        @(negedge clk_sys);
        while (!(conf_wr === 1'b1 && conf_ai === 16'h002F) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("abort 3rd seen", {31'd0, conf_wr}, 32'd1);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        send_byte(25'd0, 8'h00);
        send_byte(25'd1, 8'h20);
        send_byte(25'd2, 8'h11);
        send_byte(25'd3, 8'h22);
        dl_end;
        wait_idle("abort idle");
        exp_push(16'h1001, 8'hAA);
        exp_push(16'h002D, 8'h02);
        exp_push(16'h002E, 8'h10);
        exp_push(16'h002F, 8'h02);
        exp_push(16'h2000, 8'h11);
        exp_push(16'h2001, 8'h22);
        exp_patch(16'h2002);
        check_writes("abort");

        // Asynchronous reset mid-DATA while conf_wr is high
        dl_start(8'd3, 32'h0000_0032);
        send_byte(25'd0, 8'h77);
        send_byte(25'd1, 8'h88);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst conf", {7'd0, conf_wr, conf_ai, conf_di}, 32'd0);
        check("mid rst blk", {27'd0, cart_blk}, 32'd0);
        check("mid rst cart_reset", {31'd0, cart_reset}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        ioctl_download = 1'b0;
        tick;
        reset = 1'b0;
        exp_push(16'h2000, 8'h77);
        check_writes("mid rst");

        // Normal PRG load after reset
        dl_start(8'd1, 32'd0);
        send_byte(25'd0, 8'hFE);
        send_byte(25'd1, 8'h12);
        send_byte(25'd2, 8'h99);
        dl_end;
        wait_idle("post idle");
        exp_push(16'h12FE, 8'h99);
        exp_patch(16'h12FF);
        check_writes("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
